// File: rtl/regfile_writeback.sv
// Register-file write-back arbiter: merges ALU results with FIFO-buffered LSU/MDU results.
// Optional performance counters are built when WB_PERF_EN is defined.
module regfile_writeback #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ALU_valid,
  input  logic [4:0]      ALU_rd,
  input  logic [XLEN-1:0] ALU_data,
  output logic            ALU_stall,
  input  logic            LSU_valid,
  output logic            LSU_ready,
  input  logic [4:0]      LSU_rd,
  input  logic [XLEN-1:0] LSU_data,
  output logic            REGS_wen,
  output logic [4:0]      REGS_wraddr,
  output logic [XLEN-1:0] REGS_wrdata,
  output logic [31:0]     WB_busy,
  output logic [31:0]     PERF_wrcnt,
  output logic [31:0]     PERF_stallcnt
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [4:0]      r_fifo_rd   [DEPTH];
  logic [XLEN-1:0] r_fifo_data [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_wen;
  logic [4:0]      r_wraddr;
  logic [XLEN-1:0] r_wrdata;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_wen_d;
  logic [4:0]      w_addr_d;
  logic [XLEN-1:0] w_data_d;
  logic [CW-1:0]   w_count_d;
  logic [31:0]     w_busy;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign LSU_ready = !w_full;
  // Writes to x0 complete the handshake but are never buffered.
  assign w_push    = LSU_valid && !w_full && (LSU_rd != 5'd0);

  always_comb begin
    w_pop     = 1'b0;
    ALU_stall = 1'b0;
    w_wen_d   = 1'b0;
    w_addr_d  = r_wraddr;
    w_data_d  = r_wrdata;
    if (w_full) begin
      w_pop     = 1'b1;
      ALU_stall = ALU_valid;
      w_wen_d   = 1'b1;
      w_addr_d  = r_fifo_rd[r_rptr];
      w_data_d  = r_fifo_data[r_rptr];
    end else if (ALU_valid) begin
      if (ALU_rd != 5'd0) begin
        w_wen_d  = 1'b1;
        w_addr_d = ALU_rd;
        w_data_d = ALU_data;
      end
    end else if (!w_empty) begin
      w_pop    = 1'b1;
      w_wen_d  = 1'b1;
      w_addr_d = r_fifo_rd[r_rptr];
      w_data_d = r_fifo_data[r_rptr];
    end
  end

  assign w_count_d = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_fifo_rd[i]   <= '0;
        r_fifo_data[i] <= '0;
      end
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_wen    <= 1'b0;
      r_wraddr <= '0;
      r_wrdata <= '0;
    end else begin
      if (w_push) begin
        r_fifo_rd[r_wptr]   <= LSU_rd;
        r_fifo_data[r_wptr] <= LSU_data;
        r_wptr              <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count  <= w_count_d;
      r_wen    <= w_wen_d;
      r_wraddr <= w_addr_d;
      r_wrdata <= w_data_d;
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [PW-1:0] off;
    w_busy = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = PW'(i) - r_rptr;
      if (CW'(off) < r_count) begin
        w_busy[r_fifo_rd[i]] = 1'b1;
      end
    end
    w_busy[0] = 1'b0;
  end

  assign WB_busy     = w_busy;
  assign REGS_wen    = r_wen;
  assign REGS_wraddr = r_wraddr;
  assign REGS_wrdata = r_wrdata;

`ifdef WB_PERF_EN
  logic [31:0] r_wrcnt;
  logic [31:0] r_stallcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrcnt    <= '0;
      r_stallcnt <= '0;
    end else begin
      if (r_wen) begin
        r_wrcnt <= r_wrcnt + 32'd1;
      end
      if (ALU_valid && ALU_stall) begin
        r_stallcnt <= r_stallcnt + 32'd1;
      end
    end
  end

  assign PERF_wrcnt    = r_wrcnt;
  assign PERF_stallcnt = r_stallcnt;
`else
  assign PERF_wrcnt    = '0;
  assign PERF_stallcnt = '0;
`endif

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
Write-back arbiter and driver for the register file write port (REGS_wen/REGS_wraddr/REGS_wrdata). It merges single-cycle ALU results with variable-latency load/MDU results, which arrive through a valid/ready handshake and are buffered in a small FIFO. It drives one registered write per cycle. It also exports a pending-write mask so decode can stall on RAW/WAW hazards against buffered results.

Parameters:
XLEN, 32, data width of results and register file
DEPTH, 4, LSU result FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
ALU_valid  in  1  ALU result present this cycle
ALU_rd  in  5  ALU destination register
ALU_data  in  XLEN  ALU result
ALU_stall  out  1  ALU result not taken this cycle; pipeline holds ALU_* stable
LSU_valid  in  1  load/MDU result offered
LSU_ready  out  1  result accepted when LSU_valid && LSU_ready
LSU_rd  in  5  load/MDU destination register
LSU_data  in  XLEN  load/MDU result
REGS_wen  out  1  register file write enable
REGS_wraddr  out  5  register file write address
REGS_wrdata  out  XLEN  register file write data
WB_busy  out  32  bit i = 1 while a FIFO entry targets xi; bit 0 always 0
PERF_wrcnt  out  32  write counter (optional feature)
PERF_stallcnt  out  32  ALU stall counter (optional feature)

Behaviour:
- Reset (async, rst_n=0): REGS_wen=0, REGS_wraddr=0, REGS_wrdata=0, FIFO empty (count=0, pointers 0), WB_busy=0, perf counters 0. LSU_ready=1 and ALU_stall=0 follow combinationally from the empty FIFO. Reset mid-operation discards all buffered entries; no write is issued on the cycle after reset release unless ALU_valid.
- LSU_ready = (count != DEPTH). No pass-through when full; a pop and a push in the same cycle while full does not raise ready that cycle.
- LSU accept with LSU_rd==0: handshake completes, nothing is enqueued, count is unchanged.
- Per-cycle select (combinational, registered into REGS_* at the edge):
  1. FIFO full (count==DEPTH) and non-empty: pop head, ALU_stall = ALU_valid.
  2. Else ALU_valid: take ALU (rd 0 taken but REGS_wen=0), ALU_stall=0.
  3. Else FIFO non-empty: pop head.
  4. Else REGS_wen=0; REGS_wraddr/REGS_wrdata hold their previous values.
- Latency: ALU result at edge N appears on REGS_* after edge N (one cycle). An LSU result accepted at edge N is popped at the earliest on edge N+1, giving REGS_wen during cycle N+2. The FIFO has no bypass.
- Same-cycle read of the written register is served by the register file's write forwarding, so the output register does not contribute to WB_busy.
- Push and pop in the same cycle: count unchanged; pointers wrap modulo DEPTH.
- WB_busy = OR of one-hot(rd) over valid FIFO entries, recomputed combinationally from stored entries. Decode must not issue a writer or reader of a busy register. An ALU write to a busy rd is a protocol violation, and the bench flags it.
- Ordering: FIFO entries drain in arrival order; ALU and LSU writes to distinct registers may interleave arbitrarily.

Optional Feature:
- Macro WB_PERF_EN.
- Defined: PERF_wrcnt increments on every cycle REGS_wen is asserted. PERF_stallcnt increments on every cycle ALU_valid && ALU_stall. Both are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: both ports are present and tied to 0, and no counter logic is built.

Test Plan:
- Reset then ALU_valid=1, rd=5, data=0x1234_5678 for one cycle -> next cycle REGS_wen=1, REGS_wraddr=5, REGS_wrdata=0x12345678; WB_busy=0 throughout.
- LSU push rd=7, data=0xDEAD_BEEF with ALU idle -> WB_busy[7]=1 for one cycle; REGS_wen=1, wraddr=7 two cycles after accept; WB_busy[7] back to 0.
- DEPTH=4 pushes (rd 1..4) while ALU_valid held every cycle with rd=9 -> LSU_ready=0 after the 4th accept; ALU_stall=1 for one cycle as head rd=1 drains; then ALU rd=9 is written; PERF_stallcnt=1 with WB_PERF_EN.
- ALU_valid rd=0 and LSU push rd=0 -> no REGS_wen, count stays 0, LSU handshake completes.
- Fill FIFO with 3 entries, assert rst_n=0 asynchronously mid-cycle -> REGS_wen=0 and WB_busy=0 immediately; LSU_ready=1; no buffered write appears after release.
- 20 random LSU pushes interleaved with sparse ALU results -> every LSU write appears exactly once in push order; no cycle has two writes; WB_busy always matches the FIFO contents.
